// File: rtl/vec_exec_sequencer.sv
// vec_exec_sequencer
//   Multi-cycle execution controller for the 16-bit vector processor.
//   Takes one instruction at a time from fetch (valid/ready), decodes
//   instr[15:12], and sequences the FPU, the data-memory port
//   (element by element), scalar load-immediate writes and the PC.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   instr_i/_valid_i    instruction from fetch; instr_ready_o accepts it
//   base_addr_i         memory base address, sampled at handshake
//   fpu_start_o/op_o    FPU launch pulse and operation (00 VADD, 01 VDOT, 10 SMUL)
//   fpu_done_i          FPU completion pulse
//   mem_req_o/we_o/addr_o, mem_gnt_i, mem_rvalid_i   data-memory port
//   vrf_we_o, elem_idx_o  vector register element write strobe and index
//   sreg_we_o           scalar write strobe (SLL/SLH)
//   pc_o                program counter
//   retire_o, illegal_o one-cycle completion pulse; illegal opcode flag
//   busy_o              sequencer not idle
//
// Optional feature (macro VSEQ_PERF_CNT_EN)
//   cyc_cnt_o  32-bit count of busy cycles
//   ret_cnt_o  32-bit count of retired instructions

module vec_exec_sequencer #(
    parameter int unsigned VLEN   = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned PC_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [15:0]               instr_i,
    input  logic                      instr_valid_i,
    output logic                      instr_ready_o,
    input  logic [ADDR_W-1:0]         base_addr_i,
    output logic                      fpu_start_o,
    output logic [1:0]                fpu_op_o,
    input  logic                      fpu_done_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    output logic                      vrf_we_o,
    output logic [$clog2(VLEN)-1:0]   elem_idx_o,
    output logic                      sreg_we_o,
    output logic [PC_W-1:0]           pc_o,
    output logic                      retire_o,
    output logic                      illegal_o,
    output logic                      busy_o
`ifdef VSEQ_PERF_CNT_EN
   ,output logic [31:0]               cyc_cnt_o,
    output logic [31:0]               ret_cnt_o
`endif
);

    localparam int unsigned EW = $clog2(VLEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FPU,
        S_MEM,
        S_LDW,
        S_RET
    } state_e;

    typedef enum logic [3:0] {
        OP_VADD = 4'd0,
        OP_VDOT = 4'd1,
        OP_SMUL = 4'd2,
        OP_SST  = 4'd3,
        OP_VLD  = 4'd4,
        OP_VST  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SLH  = 4'd7,
        OP_J    = 4'd8,
        OP_NOP  = 4'd15
    } opcode_e;

    state_e            state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [EW-1:0]     elem_q,  elem_d;
    logic [PC_W-1:0]   pc_q,    pc_d;
    logic              first_q, first_d;   // first FPU cycle, gates fpu_start

    logic [3:0]        op_q;
    logic [3:0]        op_in;
    logic              last_elem;
    logic              op_illegal;
    logic [PC_W-1:0]   jmp_off;

    assign op_q       = instr_q[15:12];
    assign op_in      = instr_i[15:12];
    assign last_elem  = (elem_q == EW'(VLEN - 1));
    assign op_illegal = (op_q >= 4'd9) && (op_q <= 4'd14);
    assign jmp_off    = {{(PC_W-12){instr_q[11]}}, instr_q[11:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            base_q  <= '0;
            elem_q  <= '0;
            pc_q    <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            base_q  <= base_d;
            elem_q  <= elem_d;
            pc_q    <= pc_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        base_d  = base_q;
        elem_d  = elem_q;
        pc_d    = pc_q;
        first_d = 1'b0;

        instr_ready_o = 1'b0;
        fpu_start_o   = 1'b0;
        fpu_op_o      = 2'b00;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        vrf_we_o      = 1'b0;
        sreg_we_o     = 1'b0;
        retire_o      = 1'b0;
        illegal_o     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) begin
                    instr_d = instr_i;
                    base_d  = base_addr_i;
                    elem_d  = '0;
                    case (op_in)
                        OP_VADD, OP_VDOT, OP_SMUL: begin
                            state_d = S_FPU;
                            first_d = 1'b1;
                        end
                        OP_SST, OP_VLD, OP_VST: state_d = S_MEM;
                        default:                state_d = S_RET;
                    endcase
                end
            end

            S_FPU: begin
                fpu_start_o = first_q;
                fpu_op_o    = instr_q[13:12];
                if (fpu_done_i) state_d = S_RET;
            end

            S_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = (op_q != OP_VLD);
                if (mem_gnt_i) begin
                    if (op_q == OP_VLD) begin
                        state_d = S_LDW;
                    end else if (op_q == OP_SST || last_elem) begin
                        state_d = S_RET;
                    end else begin
                        elem_d = elem_q + EW'(1);
                    end
                end
            end

            S_LDW: begin
                if (mem_rvalid_i) begin
                    vrf_we_o = 1'b1;
                    if (last_elem) begin
                        state_d = S_RET;
                    end else begin
                        elem_d  = elem_q + EW'(1);
                        state_d = S_MEM;
                    end
                end
            end

            S_RET: begin
                retire_o  = 1'b1;
                illegal_o = op_illegal;
                sreg_we_o = (op_q == OP_SLL) || (op_q == OP_SLH);
                pc_d      = (op_q == OP_J) ? pc_q + jmp_off : pc_q + PC_W'(1);
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr_o = base_q + ADDR_W'(elem_q);
    assign elem_idx_o = elem_q;
    assign pc_o       = pc_q;
    assign busy_o     = (state_q != S_IDLE);

`ifdef VSEQ_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, ret_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            if (state_q != S_IDLE) cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (state_q == S_RET)  ret_cnt_q <= ret_cnt_q + 32'd1;
        end
    end

    assign cyc_cnt_o = cyc_cnt_q;
    assign ret_cnt_o = ret_cnt_q;
`endif

endmodule
